// File: rtl/alu_mdu_if.sv
// Execute-stage handshake bundle between the control unit (master) and alu_mdu (slave).
// valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1;
// the source holds its payload stable while valid=1 and ready=0.
interface alu_mdu_if #(
  parameter int WIDTH = 32
) ();
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       alu_ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic             zero;
  logic             busy;
  logic [1:0]       state_dbg;

  modport master (
    output flush, in_valid, A, B, alu_ctrl, out_ready,
    input  in_ready, out_valid, alu_result, zero, busy, state_dbg
  );

  modport slave (
    input  flush, in_valid, A, B, alu_ctrl, out_ready,
    output in_ready, out_valid, alu_result, zero, busy, state_dbg
  );
endinterface

// File: rtl/alu_mdu.sv
// Multi-cycle ALU with RV32M multiply/divide: base ops in one cycle, mul/div
// iterate one bit per cycle on operand magnitudes with a final sign fix.
module alu_mdu #(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     reset,
  alu_mdu_if.slave bus
);
  localparam int CNT_W = SHAMT_W + 1;
  localparam int MSB   = WIDTH - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SLL  = 5'b00100;
  localparam logic [4:0] OP_SLT  = 5'b00101;
  localparam logic [4:0] OP_SLTU = 5'b00110;
  localparam logic [4:0] OP_XOR  = 5'b00111;
  localparam logic [4:0] OP_SRL  = 5'b01000;
  localparam logic [4:0] OP_SRA  = 5'b01001;

  logic [1:0]         state;
  logic [1:0]         op_sel;   // low bits of the accepted M-op: selects hi/lo, quo/rem
  logic [WIDTH-1:0]   mcand;    // multiplicand magnitude (MUL) or divisor magnitude (DIV)
  logic [2*WIDTH-1:0] prod;     // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
  logic [CNT_W-1:0]   count;
  logic               neg_q;    // product / quotient must be negated at the end
  logic               neg_r;    // remainder must be negated at the end
  logic [WIDTH-1:0]   result_q;

  logic               is_mul, is_div, div_by_zero, div_ovf, div_special;
  logic               a_sgn, b_sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   imm_res;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, mul_fix;
  logic [WIDTH-1:0]   mul_res;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   div_res;

  assign is_mul      = (bus.alu_ctrl[4:2] == 3'b100);
  assign is_div      = (bus.alu_ctrl[4:2] == 3'b101);
  assign div_by_zero = (bus.B == '0);
  // Only the signed forms (DIV/REM, ctrl[0]=0) can overflow on MIN / -1.
  assign div_ovf     = !bus.alu_ctrl[0] && (bus.A == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.B == '1);
  assign div_special = is_div && (div_by_zero || div_ovf);
  assign shamt       = bus.B[SHAMT_W-1:0];

  // Operand signedness: MUL/MULH s*s, MULHSU s*u, MULHU u*u; DIV/REM signed, DIVU/REMU unsigned.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    if (is_mul) begin
      a_sgn = bus.A[MSB] && (bus.alu_ctrl[1:0] != 2'b11);
      b_sgn = bus.B[MSB] && !bus.alu_ctrl[1];
    end else if (is_div) begin
      a_sgn = bus.A[MSB] && !bus.alu_ctrl[0];
      b_sgn = bus.B[MSB] && !bus.alu_ctrl[0];
    end
  end

  assign a_mag = a_sgn ? -bus.A : bus.A;
  assign b_mag = b_sgn ? -bus.B : bus.B;

  // Single-cycle results: base ops, unknown codes (0) and the div/rem special cases.
  always_comb begin
    imm_res = '0;
    case (bus.alu_ctrl)
      OP_ADD:  imm_res = bus.A + bus.B;
      OP_SUB:  imm_res = bus.A - bus.B;
      OP_AND:  imm_res = bus.A & bus.B;
      OP_OR:   imm_res = bus.A | bus.B;
      OP_SLL:  imm_res = bus.A << shamt;
      OP_SLT:  imm_res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
      OP_SLTU: imm_res = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
      OP_XOR:  imm_res = bus.A ^ bus.B;
      OP_SRL:  imm_res = bus.A >> shamt;
      OP_SRA:  imm_res = $signed(bus.A) >>> shamt;
      default: imm_res = '0;
    endcase
    if (is_div) begin
      if (div_by_zero) imm_res = bus.alu_ctrl[1] ? bus.A : '1;
      else             imm_res = bus.alu_ctrl[1] ? '0 : bus.A;
    end
  end

  // One shift-add step and the sign-corrected final product.
  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    mul_next = {mul_sum, prod[WIDTH-1:1]};
    mul_fix  = neg_q ? -mul_next : mul_next;
    mul_res  = (op_sel == 2'b00) ? mul_fix[WIDTH-1:0] : mul_fix[2*WIDTH-1:WIDTH];
  end

  // One restoring-division step and the sign-corrected quotient/remainder.
  always_comb begin
    div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mcand});
    div_diff  = div_shift[WIDTH-1:0] - mcand;
    div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), prod[WIDTH-2:0], div_ge};
    if (op_sel[1]) div_res = neg_r ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
    else           div_res = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
  end

  // Control FSM and iteration datapath; flush wins over every other transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      op_sel   <= '0;
      mcand    <= '0;
      prod     <= '0;
      count    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_sel <= bus.alu_ctrl[1:0];
            neg_q  <= a_sgn ^ b_sgn;
            neg_r  <= a_sgn;
            count  <= CNT_W'(WIDTH);
            if (is_mul) begin
              mcand <= a_mag;
              prod  <= {{WIDTH{1'b0}}, b_mag};
              state <= S_MUL;
            end else if (is_div && !div_special) begin
              mcand <= b_mag;
              prod  <= {{WIDTH{1'b0}}, a_mag};
              state <= S_DIV;
            end else begin
              result_q <= imm_res;
              state    <= S_DONE;
            end
          end
        end
        S_MUL: begin
          prod  <= mul_next;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            result_q <= mul_res;
            state    <= S_DONE;
          end
        end
        S_DIV: begin
          prod  <= div_next;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            result_q <= div_res;
            state    <= S_DONE;
          end
        end
        default: begin
          if (bus.out_ready) state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = (state == S_IDLE);
  assign bus.out_valid  = (state == S_DONE);
  assign bus.busy       = (state == S_MUL) || (state == S_DIV);
  assign bus.alu_result = result_q;
  assign bus.zero       = (result_q == '0);
  assign bus.state_dbg  = state;
endmodule

// File: tb/tb_alu_mdu.sv
// Directed + random bench for alu_mdu: expected results come from a 64-bit
// reference model, are queued at drive time and popped when out_valid rises.
module tb_alu_mdu;
  localparam int W = 32;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b00001;
  localparam logic [4:0] OP_AND    = 5'b00010;
  localparam logic [4:0] OP_OR     = 5'b00011;
  localparam logic [4:0] OP_SLL    = 5'b00100;
  localparam logic [4:0] OP_SLT    = 5'b00101;
  localparam logic [4:0] OP_SLTU   = 5'b00110;
  localparam logic [4:0] OP_XOR    = 5'b00111;
  localparam logic [4:0] OP_SRL    = 5'b01000;
  localparam logic [4:0] OP_SRA    = 5'b01001;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_mdu_if #(.WIDTH(W)) bus ();
  alu_mdu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    p  = '0;
    case (c)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_SLL:  return a << b[4:0];
      OP_SLT:  return {31'b0, sa < sb};
      OP_SLTU: return {31'b0, a < b};
      OP_XOR:  return a ^ b;
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return W'(sa >>> b[4:0]);
      OP_MUL: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        return p[31:0];
      end
      OP_MULH: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        return p[63:32];
      end
      OP_MULHSU: begin
        p = {{32{a[31]}}, a} * {32'b0, b};
        return p[63:32];
      end
      OP_MULHU: begin
        p = {32'b0, a} * {32'b0, b};
        return p[63:32];
      end
      OP_DIV: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return W'(sa / sb);
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        return W'(sa % sb);
      end
      OP_DIVU: return (b == 0) ? '1 : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  function automatic int latency(input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    if (c[4:2] == 3'b100) return W + 1;
    if (c[4:2] == 3'b101) begin
      if (b == 0) return 1;
      if (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return W + 1;
    end
    return 1;
  endfunction

  // ---------------- driver ----------------
  // Issue one op with out_ready=1, measure accept->out_valid latency and busy cycles.
  task automatic run_op(input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] e;
    int cyc, nbusy, exp_lat;
    exp_lat = latency(c, a, b);
    @(negedge clk);
    chk({tag, "/in_ready"}, 64'(bus.in_ready), 64'(1));
    bus.in_valid  = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.alu_ctrl  = c;
    bus.out_ready = 1'b1;
    exp_q.push_back(model(c, a, b));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cyc   = 1;
    nbusy = 0;
    while (!bus.out_valid && cyc < 100) begin
      if (bus.busy) nbusy++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "/latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "/busy_cycles"}, 64'(nbusy), 64'(exp_lat - 1));
    e = exp_q.pop_front();
    chk({tag, "/result"}, 64'(bus.alu_result), 64'(e));
    chk({tag, "/zero"}, 64'(bus.zero), 64'(e == 0));
    @(posedge clk);
    #1;
    chk({tag, "/handoff"}, 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  logic [W-1:0] e;
  logic [W-1:0] ra, rb;
  logic [4:0]   rc;
  logic [4:0]   ops[18];
  int           cyc;
  logic         seen_valid;

  initial begin
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.alu_ctrl  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset/result", 64'(bus.alu_result), 64'(0));
    chk("reset/zero", 64'(bus.zero), 64'(1));
    chk("reset/flags", 64'({bus.out_valid, bus.busy, bus.in_ready}), 64'(3'b001));
    chk("reset/state", 64'(bus.state_dbg), 64'(0));

    // Base ops
    run_op(OP_ADD,  32'h7FFF_FFFF, 32'h1,          "add_ovf");
    run_op(OP_SUB,  32'd5,         32'd5,          "sub_zero");
    run_op(OP_SRA,  32'h8000_0000, 32'h0000_0024,  "sra");
    run_op(OP_SLT,  32'hFFFF_FFFF, 32'h1,          "slt");
    run_op(OP_SLTU, 32'hFFFF_FFFF, 32'h1,          "sltu");
    run_op(OP_SLL,  32'h0000_0003, 32'hFFFF_FFFF,  "sll_shamt");
    run_op(5'b01010, 32'h1234_5678, 32'h1,         "unknown_op");

    // Multiply family
    run_op(OP_MUL,    32'hFFFF_FFFE, 32'h3, "mul");
    run_op(OP_MULH,   32'hFFFF_FFFE, 32'h3, "mulh");
    run_op(OP_MULHSU, 32'hFFFF_FFFE, 32'h3, "mulhsu");
    run_op(OP_MULHU,  32'hFFFF_FFFE, 32'h3, "mulhu");
    run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, "mulh_min");

    // Divide family and special cases
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, "div_neg");
    run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, "rem_neg");
    run_op(OP_DIVU, 32'd7,         32'd2, "divu");
    run_op(OP_REM,  32'd7,         32'hFFFF_FFFE, "rem_pos_neg");
    run_op(OP_DIV,  32'd1234,      32'd0, "div_by0");
    run_op(OP_REMU, 32'h0000_1234, 32'd0, "remu_by0");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");

    // Random mix with edge-biased operands
    for (int i = 0; i < 24; i++) begin
      rc = ops[$urandom_range(0, 17)];
      case ($urandom_range(0, 4))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'h0;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'hFFFF_FFFF;
        1: rb = 32'h0;
        2: rb = $urandom_range(1, 40);
        default: rb = $urandom;
      endcase
      run_op(rc, ra, rb, $sformatf("rand%0d_op%0h", i, rc));
    end

    // Backpressure: completed MUL held for 10 cycles
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.A         = 32'hFFFF_FFFE;
    bus.B         = 32'h3;
    bus.alu_ctrl  = OP_MUL;
    exp_q.push_back(model(OP_MUL, 32'hFFFF_FFFE, 32'h3));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("bp/latency", 64'(cyc), 64'(W + 1));
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp/hold%0d", i), 64'({bus.alu_result, bus.out_valid, bus.in_ready}), 64'({e, 1'b1, 1'b0}));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp/release", 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));

    // flush together with in_valid in IDLE: op must not be accepted
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.A         = 32'd9;
    bus.B         = 32'd9;
    bus.alu_ctrl  = OP_ADD;
    @(posedge clk);
    #1;
    chk("flush_accept/state", 64'({bus.out_valid, bus.busy, bus.in_ready}), 64'(3'b001));
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;

    // flush in DONE beats a stalled consumer
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.alu_ctrl  = OP_ADD;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("flush_done/valid", 64'(bus.out_valid), 64'(1));
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_done/dropped", 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // flush in the middle of a DIV
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = 32'd1000;
    bus.B        = 32'd7;
    bus.alu_ctrl = OP_DIV;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("flush_div/busy_before", 64'(bus.busy), 64'(1));
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_div/idle", 64'({bus.state_dbg, bus.busy, bus.in_ready}), 64'({2'd0, 1'b0, 1'b1}));
    @(negedge clk);
    bus.flush = 1'b0;
    seen_valid = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen_valid = 1'b1;
    end
    chk("flush_div/no_valid", 64'(seen_valid), 64'(0));

    // asynchronous reset mid-MUL, after a nonzero result is registered
    run_op(OP_ADD, 32'd40, 32'd2, "pre_reset_add");
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = 32'h1234_5678;
    bus.B        = 32'h9ABC_DEF0;
    bus.alu_ctrl = OP_MULHU;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("areset/busy_before", 64'(bus.busy), 64'(1));
    reset = 1'b1;
    #1;
    chk("areset/result", 64'(bus.alu_result), 64'(0));
    chk("areset/flags", 64'({bus.out_valid, bus.busy, bus.in_ready, bus.zero}), 64'(4'b0011));
    @(negedge clk);
    reset = 1'b0;
    run_op(OP_ADD, 32'h0000_00FF, 32'h0000_0101, "post_reset_add");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
